// File: rtl/axi_store_unit_pkg.sv
// Shared types for the AXI store unit: store sizes, AXI constants and the store-buffer entry.
package axi_store_unit_pkg;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} store_size_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         SB_ADDR_W      = 64;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [63:0]          data;
        store_size_t          size;
    } sb_entry_t;

    // Byte-enable pattern of a right-justified store before lane alignment.
    function automatic logic [7:0] size_mask(store_size_t s);
        case (s)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/axi_store_unit_fifo.sv
// Store buffer: DEPTH-entry FIFO of sb_entry_t with an occupancy vector for address snooping.
module store_fifo
    import axi_store_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  sb_entry_t                  din,
    input  logic                       pop,
    output sb_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DEPTH-1:0]           valid,
    output sb_entry_t [DEPTH-1:0]      entries
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         rd_ptr, wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Slot i is live when its distance from the read pointer is below the count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
        end
    end

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign entries = mem;

endmodule

// File: rtl/axi_store_unit.sv
// Write-side AXI master: queues MEM stores and issues each as a single-beat AW/W/B transaction.
// Optional address snoop against pending stores is enabled with STORE_SNOOP_EN.
module axi_store_unit
    import axi_store_unit_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int BUF_DEPTH  = 4,
    parameter int AXI_WID    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_size,
    output logic                  sb_empty,
    output logic                  write_done,
    output logic [1:0]            err,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    output logic                  snoop_hit,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                         state, state_n;
    logic                           aw_done, w_done, aw_done_n, w_done_n;
    logic                           full, empty, push, pop, latch, misalign;
    logic [$clog2(BUF_DEPTH):0]     count;
    logic [BUF_DEPTH-1:0]           valid;
    sb_entry_t                      head, din;
    sb_entry_t [BUF_DEPTH-1:0]      entries;
    logic [1:0]                     cur_size;
    logic                           unused_bits;

    always_comb begin
        misalign = 1'b0;
        case (store_size_t'(req_size))
            SZ_B:    misalign = 1'b0;
            SZ_H:    misalign = req_addr[0];
            SZ_W:    misalign = |req_addr[1:0];
            default: misalign = |req_addr[2:0];
        endcase
    end

    assign req_ready = !full;
    assign push      = req_valid && req_ready && !misalign;
    assign din       = '{addr: SB_ADDR_W'(req_addr), data: req_data, size: store_size_t'(req_size)};

    store_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .din     (din),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .valid   (valid),
        .entries (entries)
    );

    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        pop       = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                latch     = 1'b1;
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                state_n   = ISSUE;
            end
            ISSUE: begin
                if (m_axi_awvalid && m_axi_awready) aw_done_n = 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_n  = 1'b1;
                if (aw_done_n && w_done_n)          state_n   = RESP;
            end
            RESP: if (m_axi_bvalid) begin
                pop     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            write_done <= 1'b0;
            err        <= '0;
        end else begin
            state      <= state_n;
            aw_done    <= aw_done_n;
            w_done     <= w_done_n;
            write_done <= pop;
            err        <= {pop && (m_axi_bresp != AXI_RESP_OKAY), req_valid && req_ready && misalign};
        end
    end

    // Payload is frozen at issue so AW/W stay stable while the slave stalls.
    always_ff @(posedge clk) begin
        if (latch) begin
            m_axi_awaddr <= head.addr[ADDR_WIDTH-1:0];
            cur_size     <= head.size;
            m_axi_wdata  <= head.data << {head.addr[2:0], 3'b000};
            m_axi_wstrb  <= size_mask(head.size) << head.addr[2:0];
        end
    end

    assign m_axi_awvalid = (state == ISSUE) && !aw_done;
    assign m_axi_wvalid  = (state == ISSUE) && !w_done;
    assign m_axi_bready  = (state == RESP);
    assign m_axi_awsize  = {1'b0, cur_size};
    assign m_axi_awid    = ID_WIDTH'(AXI_WID);
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_wlast   = 1'b1;
    assign sb_empty      = empty && (state == IDLE);

`ifdef STORE_SNOOP_EN
    // The in-flight head stays in the FIFO until its B response, so it is covered here.
    always_comb begin
        snoop_hit = 1'b0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (valid[i] && entries[i].addr[ADDR_WIDTH-1:3] == snoop_addr[ADDR_WIDTH-1:3])
                snoop_hit = 1'b1;
        end
    end
    assign unused_bits = ^{m_axi_bid, entries, count};
`else
    assign snoop_hit   = 1'b0;
    assign unused_bits = ^{m_axi_bid, entries, count, valid, snoop_addr};
`endif

endmodule
